// File: rtl/alu_operand_stage.sv
// Operand-fetch pipeline stage in front of the ALU: resolves rs/rt/imm operands with
// EX/WB bypassing and keeps them fresh while stalled. Bypass logic is enabled by ALU_OPERAND_FWD_EN.
package alu_operand_pkg;

  typedef logic [31:0] bus_type;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_oper_type;

endpackage

module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs_addr,
  input  logic [REG_ADDR_W-1:0] in_rt_addr,
  input  bus_type               in_rs_data,
  input  bus_type               in_rt_data,
  input  bus_type               in_imm,
  input  logic                  in_use_imm,
  input  alu_oper_type          in_sel,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,

  input  logic                  flush,

  input  logic                  fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0] fwd_ex_addr,
  input  bus_type               fwd_ex_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_addr,
  input  bus_type               fwd_wb_data,

  output logic                  out_valid,
  input  logic                  out_ready,
  output bus_type               out_a,
  output bus_type               out_b,
  output alu_oper_type          out_sel,
  output logic [REG_ADDR_W-1:0] out_rd_addr,

  output logic [31:0]           stall_count
);

  // Registered operation and the source information needed to refresh it while held
  logic                  out_valid_q, out_valid_d;
  bus_type               a_q, a_d;
  bus_type               b_q, b_d;
  alu_oper_type          sel_q, sel_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic                  use_imm_q, use_imm_d;
  logic [31:0]           stall_q, stall_d;

  logic    capture;
  logic    hold;
  bus_type rs_resolved;
  bus_type rt_resolved;

  assign in_ready = (!out_valid_q || out_ready) && !flush && !reset;
  assign capture  = in_valid && in_ready;
  assign hold     = out_valid_q && !out_ready && !flush;

`ifdef ALU_OPERAND_FWD_EN
  // Register 0 is hardwired to zero and must never pick up bypassed data
  function automatic bus_type resolve(
    input logic [REG_ADDR_W-1:0] addr,
    input bus_type               rf_data,
    input logic                  ex_v,
    input logic [REG_ADDR_W-1:0] ex_a,
    input bus_type               ex_d,
    input logic                  wb_v,
    input logic [REG_ADDR_W-1:0] wb_a,
    input bus_type               wb_d
  );
    bus_type res;
    if (addr == '0) begin
      res = '0;
    end else if (ex_v && (ex_a == addr)) begin
      res = ex_d;
    end else if (wb_v && (wb_a == addr)) begin
      res = wb_d;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  assign rs_resolved = resolve(in_rs_addr, in_rs_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                               fwd_wb_valid, fwd_wb_addr, fwd_wb_data);
  assign rt_resolved = resolve(in_rt_addr, in_rt_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                               fwd_wb_valid, fwd_wb_addr, fwd_wb_data);

  logic hold_rs_hit;
  logic hold_rt_hit;

  // Only write-back can land while stalled; the ALU is waiting on this stage
  assign hold_rs_hit = fwd_wb_valid && (rs_addr_q != '0) && (fwd_wb_addr == rs_addr_q);
  assign hold_rt_hit = fwd_wb_valid && !use_imm_q && (rt_addr_q != '0)
                       && (fwd_wb_addr == rt_addr_q);
`else
  assign rs_resolved = (in_rs_addr == '0) ? '0 : in_rs_data;
  assign rt_resolved = (in_rt_addr == '0) ? '0 : in_rt_data;

  logic hold_rs_hit;
  logic hold_rt_hit;
  logic unused_fwd;

  assign hold_rs_hit = 1'b0;
  assign hold_rt_hit = 1'b0;
  assign unused_fwd  = ^{fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                         fwd_wb_valid, fwd_wb_addr, fwd_wb_data};
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    rd_addr_d   = rd_addr_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    use_imm_d   = use_imm_q;
    stall_d     = stall_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (capture) begin
      a_d       = rs_resolved;
      b_d       = in_use_imm ? in_imm : rt_resolved;
      sel_d     = in_sel;
      rd_addr_d = in_rd_addr;
      rs_addr_d = in_rs_addr;
      rt_addr_d = in_rt_addr;
      use_imm_d = in_use_imm;
    end else if (hold) begin
      if (hold_rs_hit) begin
        a_d = fwd_wb_data;
      end
      if (hold_rt_hit) begin
        b_d = fwd_wb_data;
      end
    end

    // Counts every stalled cycle, wrapping naturally at 32 bits
    if (out_valid_q && !out_ready) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= ALU_ADD;
      rd_addr_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      use_imm_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      rd_addr_q   <= rd_addr_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      use_imm_q   <= use_imm_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_sel     = sel_q;
  assign out_rd_addr = rd_addr_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table of single captures plus stall/flush/reset sequences.
module tb_alu_operand_stage;
  import alu_operand_pkg::*;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rs_addr, in_rt_addr, in_rd_addr;
  bus_type      in_rs_data, in_rt_data, in_imm;
  logic         in_use_imm;
  alu_oper_type in_sel;
  logic         flush;
  logic         fwd_ex_valid, fwd_wb_valid;
  logic [4:0]   fwd_ex_addr, fwd_wb_addr;
  bus_type      fwd_ex_data, fwd_wb_data;
  logic         out_valid, out_ready;
  bus_type      out_a, out_b;
  alu_oper_type out_sel;
  logic [4:0]   out_rd_addr;
  logic [31:0]  stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sel(in_sel), .in_rd_addr(in_rd_addr),
    .flush(flush),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sel(out_sel), .out_rd_addr(out_rd_addr),
    .stall_count(stall_count)
  );

  typedef struct {
    logic [4:0]   rs_addr;
    logic [31:0]  rs_data;
    logic [4:0]   rt_addr;
    logic [31:0]  rt_data;
    logic [31:0]  imm;
    logic         use_imm;
    alu_oper_type sel;
    logic [4:0]   rd;
    logic         ex_v;
    logic [4:0]   ex_addr;
    logic [31:0]  ex_data;
    logic         wb_v;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic [31:0]  a_f;
    logic [31:0]  b_f;
    logic [31:0]  a_n;
    logic [31:0]  b_n;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_rs_addr   = 5'd0;
    in_rt_addr   = 5'd0;
    in_rd_addr   = 5'd0;
    in_rs_data   = 32'h0;
    in_rt_data   = 32'h0;
    in_imm       = 32'h0;
    in_use_imm   = 1'b0;
    in_sel       = ALU_ADD;
    fwd_ex_valid = 1'b0;
    fwd_ex_addr  = 5'd0;
    fwd_ex_data  = 32'h0;
    fwd_wb_valid = 1'b0;
    fwd_wb_addr  = 5'd0;
    fwd_wb_data  = 32'h0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid     = 1'b1;
    in_rs_addr   = v.rs_addr;
    in_rs_data   = v.rs_data;
    in_rt_addr   = v.rt_addr;
    in_rt_data   = v.rt_data;
    in_imm       = v.imm;
    in_use_imm   = v.use_imm;
    in_sel       = v.sel;
    in_rd_addr   = v.rd;
    fwd_ex_valid = v.ex_v;
    fwd_ex_addr  = v.ex_addr;
    fwd_ex_data  = v.ex_data;
    fwd_wb_valid = v.wb_v;
    fwd_wb_addr  = v.wb_addr;
    fwd_wb_data  = v.wb_data;
  endtask

  initial begin
    vecs[0] = '{5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 1'b0, ALU_ADD, 5'd1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h10, 32'h20, 32'h10, 32'h20};
    vecs[1] = '{5'd5, 32'h55, 5'd6, 32'h66, 32'h0, 1'b0, ALU_SUB, 5'd2,
                1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
                32'hAAAA, 32'h66, 32'h55, 32'h66};
    vecs[2] = '{5'd0, 32'h77, 5'd0, 32'h12, 32'h0, 1'b0, ALU_AND, 5'd3,
                1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{5'd9, 32'h1, 5'd10, 32'h2, 32'h0, 1'b0, ALU_OR, 5'd4,
                1'b1, 5'd10, 32'hE0, 1'b1, 5'd9, 32'hC0DE,
                32'hC0DE, 32'hE0, 32'h1, 32'h2};
    vecs[4] = '{5'd7, 32'h3, 5'd7, 32'h3, 32'hFFFF_FFFC, 1'b1, ALU_XOR, 5'd5,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h5,
                32'h5, 32'hFFFF_FFFC, 32'h3, 32'hFFFF_FFFC};
    vecs[5] = '{5'd2, 32'h22, 5'd8, 32'h88, 32'h0, 1'b0, ALU_SLT, 5'd6,
                1'b0, 5'd2, 32'hBAD, 1'b0, 5'd8, 32'hBAD,
                32'h22, 32'h88, 32'h22, 32'h88};
    vecs[6] = '{5'd11, 32'hB, 5'd12, 32'hC, 32'h5, 1'b0, ALU_SLL, 5'd31,
                1'b1, 5'd12, 32'h1200, 1'b1, 5'd12, 32'h2200,
                32'hB, 32'h1200, 32'hB, 32'hC};

    idle_inputs();
    flush     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk("ready_in_reset", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a", out_a, 32'h0);
    chk("rst_b", out_b, 32'h0);
    chk("rst_sel", 32'(out_sel), 32'(ALU_ADD));
    chk("rst_rd", 32'(out_rd_addr), 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Back-to-back captures with the ALU always ready
    for (int i = 0; i < 7; i++) begin
      drive_vec(vecs[i]);
      tick();
      $display("vec %0d: a=0x%08h b=0x%08h sel=%0d rd=%0d", i, out_a, out_b, out_sel, out_rd_addr);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_a", i), out_a, FWD ? vecs[i].a_f : vecs[i].a_n);
      chk($sformatf("vec%0d_b", i), out_b, FWD ? vecs[i].b_f : vecs[i].b_n);
      chk($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
    end
    idle_inputs();
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_keep_a", out_a, FWD ? vecs[6].a_f : vecs[6].a_n);

    // Stall with a write-back to the held rt register in the second cycle
    in_valid = 1'b1; in_rs_addr = 5'd1; in_rs_data = 32'h11;
    in_rt_addr = 5'd7; in_rt_data = 32'h1; in_sel = ALU_SUB; in_rd_addr = 5'd9;
    tick();
    $display("stall seq: captured a=0x%08h b=0x%08h", out_a, out_b);
    chk("st_cap_b", out_b, 32'h1);
    in_rs_data = 32'hDEAD; in_rt_data = 32'hBEEF; in_sel = ALU_OR; in_rd_addr = 5'd3;
    out_ready = 1'b0;
    #1;
    chk("st_ready_c1", 32'(in_ready), 32'd0);
    tick();
    fwd_wb_valid = 1'b1; fwd_wb_addr = 5'd7; fwd_wb_data = 32'h99;
    #1;
    chk("st_ready_c2", 32'(in_ready), 32'd0);
    tick();
    fwd_wb_valid = 1'b0;
    chk("st_b_c2", out_b, FWD ? 32'h99 : 32'h1);
    #1;
    chk("st_ready_c3", 32'(in_ready), 32'd0);
    tick();
    $display("stall seq: after hold a=0x%08h b=0x%08h stall=%0d", out_a, out_b, stall_count);
    chk("st_b_c3", out_b, FWD ? 32'h99 : 32'h1);
    chk("st_a_c3", out_a, 32'h11);
    chk("st_sel_c3", 32'(out_sel), 32'(ALU_SUB));
    chk("st_rd_c3", 32'(out_rd_addr), 32'd9);
    chk("st_valid_c3", 32'(out_valid), 32'd1);
    chk("st_count", stall_count, 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("st_done_valid", 32'(out_valid), 32'd0);
    chk("st_done_count", stall_count, 32'd3);

    // Held immediate is immune to write-back; rs of the same register is refreshed
    idle_inputs();
    in_valid = 1'b1; in_rs_addr = 5'd7; in_rs_data = 32'h3;
    in_rt_addr = 5'd7; in_rt_data = 32'h3; in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    fwd_wb_valid = 1'b1; fwd_wb_addr = 5'd7; fwd_wb_data = 32'h5;
    tick();
    tick();
    $display("imm seq: a=0x%08h b=0x%08h stall=%0d", out_a, out_b, stall_count);
    chk("imm_b_held", out_b, 32'hFFFF_FFFC);
    chk("imm_a_held", out_a, FWD ? 32'h5 : 32'h3);
    chk("imm_count", stall_count, 32'd5);

    // Flush while holding, with a new operation offered
    idle_inputs();
    flush = 1'b1; in_valid = 1'b1; in_rs_addr = 5'd4; in_rs_data = 32'h4444;
    #1;
    chk("fl_ready", 32'(in_ready), 32'd0);
    tick();
    $display("flush seq: valid=%0d a=0x%08h", out_valid, out_a);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_a_kept", out_a, FWD ? 32'h5 : 32'h3);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_still_idle", 32'(out_valid), 32'd0);

    // Reset arriving in the middle of a stall
    out_ready = 1'b1; in_valid = 1'b1; in_rs_addr = 5'd6; in_rs_data = 32'h66;
    in_rt_addr = 5'd8; in_rt_data = 32'h88; in_sel = ALU_SRA; in_rd_addr = 5'd12;
    tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mr_ready", 32'(in_ready), 32'd0);
    tick();
    $display("reset seq: valid=%0d a=0x%08h b=0x%08h stall=%0d", out_valid, out_a, out_b, stall_count);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_a", out_a, 32'h0);
    chk("mr_b", out_b, 32'h0);
    chk("mr_sel", 32'(out_sel), 32'(ALU_ADD));
    chk("mr_rd", 32'(out_rd_addr), 32'd0);
    chk("mr_stall", stall_count, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("mr_idle", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
